// File: rtl/tag_way_manager.sv
// Set-associative tag/valid store with per-set replacement and a 3-state pipeline.
// Define TAG_WAY_MGR_LRU_EN for true LRU replacement; otherwise round-robin.
module tag_way_manager #(
  parameter int i_size = 20,
  parameter int c_size = 12,
  parameter int a_size = 8,
  parameter int d_size = 6,
  localparam int idx_w = c_size - d_size - $clog2(a_size),
  localparam int tag_w = i_size - idx_w - d_size,
  localparam int way_w = $clog2(a_size)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [i_size-1:0] req_addr,
  input  logic              req_inv,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [way_w-1:0]  resp_way,
  output logic              resp_evict,
  output logic [tag_w-1:0]  resp_evict_tag
);

  localparam int n_sets = 1 << idx_w;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;

  logic [1:0]       r_state;
  logic [tag_w-1:0] r_tag;
  logic [idx_w-1:0] r_idx;
  logic             r_inv;

  logic             r_hit;
  logic [way_w-1:0] r_way;
  logic             r_evict;
  logic [tag_w-1:0] r_evict_tag;

  logic [tag_w-1:0]  r_tags  [n_sets][a_size];
  logic [a_size-1:0] r_valid [n_sets];

`ifdef TAG_WAY_MGR_LRU_EN
  logic [way_w-1:0] r_age [n_sets][a_size];
`else
  logic [way_w-1:0] r_ptr [n_sets];
`endif

  logic             w_accept;
  logic             w_resp;
  logic             w_hit;
  logic [way_w-1:0] w_hit_way;
  logic             w_has_inv;
  logic [way_w-1:0] w_inv_way;
  logic [way_w-1:0] w_victim;
  logic             w_unused_ofs;

  // Offset bits select bytes within a block and play no part here.
  assign w_unused_ofs = &{1'b0, req_addr[d_size-1:0]};

  assign req_ready = (r_state == S_IDLE) && !reset;
  assign w_accept  = req_valid && req_ready;
  assign w_resp    = (r_state == S_UPDATE) && !reset;

  assign resp_valid     = w_resp;
  assign resp_hit       = w_resp && r_hit;
  assign resp_way       = w_resp ? r_way : '0;
  assign resp_evict     = w_resp && r_evict;
  assign resp_evict_tag = w_resp ? r_evict_tag : '0;

  // Tag compare and first-free search; descending scan leaves the lowest way.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int i = a_size - 1; i >= 0; i--) begin
      if (r_valid[r_idx][i] && (r_tags[r_idx][i] == r_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = way_w'(i);
      end
      if (!r_valid[r_idx][i]) begin
        w_has_inv = 1'b1;
        w_inv_way = way_w'(i);
      end
    end
  end

`ifdef TAG_WAY_MGR_LRU_EN
  // The oldest way (age a_size-1) is the replacement victim.
  always_comb begin
    w_victim = '0;
    for (int i = 0; i < a_size; i++) begin
      if (r_age[r_idx][i] == way_w'(a_size - 1)) begin
        w_victim = way_w'(i);
      end
    end
  end
`else
  assign w_victim = r_ptr[r_idx];
`endif

  // Request capture, lookup result registration and state sequencing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tag       <= '0;
      r_idx       <= '0;
      r_inv       <= 1'b0;
      r_hit       <= 1'b0;
      r_way       <= '0;
      r_evict     <= 1'b0;
      r_evict_tag <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tag   <= req_addr[i_size-1:idx_w+d_size];
            r_idx   <= req_addr[idx_w+d_size-1:d_size];
            r_inv   <= req_inv;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_hit       <= w_hit;
          r_evict     <= 1'b0;
          r_evict_tag <= '0;
          if (r_inv) begin
            r_way <= w_hit ? w_hit_way : '0;
          end else if (w_hit) begin
            r_way <= w_hit_way;
          end else if (w_has_inv) begin
            r_way <= w_inv_way;
          end else begin
            r_way       <= w_victim;
            r_evict     <= 1'b1;
            r_evict_tag <= r_tags[r_idx][w_victim];
          end
          r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Commit tag, valid and replacement state for the set under update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < n_sets; s++) begin
        r_valid[s] <= '0;
`ifdef TAG_WAY_MGR_LRU_EN
        for (int i = 0; i < a_size; i++) begin
          r_age[s][i] <= way_w'(i);
        end
`else
        r_ptr[s] <= '0;
`endif
      end
    end else if (r_state == S_UPDATE) begin
      if (r_inv) begin
        if (r_hit) begin
          r_valid[r_idx][r_way] <= 1'b0;
        end
      end else begin
        if (!r_hit) begin
          r_tags[r_idx][r_way]  <= r_tag;
          r_valid[r_idx][r_way] <= 1'b1;
        end
`ifdef TAG_WAY_MGR_LRU_EN
        for (int i = 0; i < a_size; i++) begin
          if (r_age[r_idx][i] < r_age[r_idx][r_way]) begin
            r_age[r_idx][i] <= r_age[r_idx][i] + 1'b1;
          end
        end
        r_age[r_idx][r_way] <= '0;
`else
        if (r_evict) begin
          r_ptr[r_idx] <= r_ptr[r_idx] + 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_tag_way_manager.sv
// Scoreboard bench for tag_way_manager at default parameters.
// Follows TAG_WAY_MGR_LRU_EN to pick the matching replacement model.
module tb_tag_way_manager;

  localparam int I_SIZE = 20;
  localparam int C_SIZE = 12;
  localparam int A      = 8;
  localparam int D_SIZE = 6;
  localparam int IDX_W  = C_SIZE - D_SIZE - $clog2(A);
  localparam int TAG_W  = I_SIZE - IDX_W - D_SIZE;
  localparam int WAY_W  = $clog2(A);
  localparam int NSETS  = 1 << IDX_W;

  typedef struct {
    logic             hit;
    logic [WAY_W-1:0] way;
    logic             evict;
    logic [TAG_W-1:0] etag;
    int               acc;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [I_SIZE-1:0] req_addr;
  logic              req_inv;
  logic              resp_valid;
  logic              resp_hit;
  logic [WAY_W-1:0]  resp_way;
  logic              resp_evict;
  logic [TAG_W-1:0]  resp_evict_tag;

  tag_way_manager dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_inv        (req_inv),
    .resp_valid     (resp_valid),
    .resp_hit       (resp_hit),
    .resp_way       (resp_way),
    .resp_evict     (resp_evict),
    .resp_evict_tag (resp_evict_tag)
  );

  int   n_chk;
  int   n_fail;
  int   n_resp;
  int   cyc;
  exp_t q[$];

  logic             last_hit;
  logic [WAY_W-1:0] last_way;
  logic             last_evict;
  logic [TAG_W-1:0] last_etag;
  int               last_lat;

  logic [TAG_W-1:0] m_tag [NSETS][A];
  bit               m_val [NSETS][A];
`ifdef TAG_WAY_MGR_LRU_EN
  int               m_age [NSETS][A];
`else
  int               m_ptr [NSETS];
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++) begin
      for (int i = 0; i < A; i++) begin
        m_val[s][i] = 1'b0;
        m_tag[s][i] = '0;
`ifdef TAG_WAY_MGR_LRU_EN
        m_age[s][i] = i;
`endif
      end
`ifndef TAG_WAY_MGR_LRU_EN
      m_ptr[s] = 0;
`endif
    end
  endtask

  task automatic model_req(input logic [I_SIZE-1:0] a, input logic inv,
                           output exp_t e);
    logic [TAG_W-1:0] t;
    int s;
    int hw;
    int w;
    e.hit   = 1'b0;
    e.way   = '0;
    e.evict = 1'b0;
    e.etag  = '0;
    e.acc   = 0;
    t  = a[I_SIZE-1:IDX_W+D_SIZE];
    s  = int'(a[IDX_W+D_SIZE-1:D_SIZE]);
    hw = -1;
    for (int i = A - 1; i >= 0; i--)
      if (m_val[s][i] && m_tag[s][i] == t) hw = i;
    if (inv) begin
      if (hw >= 0) begin
        e.hit = 1'b1;
        e.way = WAY_W'(hw);
        m_val[s][hw] = 1'b0;
      end
    end else begin
      if (hw >= 0) begin
        e.hit = 1'b1;
        w = hw;
      end else begin
        w = -1;
        for (int i = A - 1; i >= 0; i--)
          if (!m_val[s][i]) w = i;
        if (w < 0) begin
`ifdef TAG_WAY_MGR_LRU_EN
          for (int i = 0; i < A; i++)
            if (m_age[s][i] == A - 1) w = i;
`else
          w = m_ptr[s];
          m_ptr[s] = (m_ptr[s] + 1) % A;
`endif
          e.evict = 1'b1;
          e.etag  = m_tag[s][w];
        end
        m_tag[s][w] = t;
        m_val[s][w] = 1'b1;
      end
      e.way = WAY_W'(w);
`ifdef TAG_WAY_MGR_LRU_EN
      begin
        int aw;
        aw = m_age[s][w];
        for (int j = 0; j < A; j++)
          if (m_age[s][j] < aw) m_age[s][j] = m_age[s][j] + 1;
        m_age[s][w] = 0;
      end
`endif
    end
  endtask

  // Response side: pop and compare, and insist on quiet outputs otherwise.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_resp_valid", resp_valid, 0);
      check("rst_req_ready", req_ready, 0);
    end else if (resp_valid) begin
      n_resp++;
      last_hit   = resp_hit;
      last_way   = resp_way;
      last_evict = resp_evict;
      last_etag  = resp_evict_tag;
      if (q.size() == 0) begin
        check("spurious_resp", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        last_lat = cyc - e.acc;
        check("hit", resp_hit, e.hit);
        check("way", resp_way, e.way);
        check("evict", resp_evict, e.evict);
        if (e.evict) check("evict_tag", resp_evict_tag, e.etag);
        check("latency", last_lat, 2);
      end
    end else begin
      check("idle_zero",
            {resp_hit, resp_way, resp_evict, resp_evict_tag}, 0);
    end
  end

  task automatic send(input logic [I_SIZE-1:0] a, input logic inv,
                      input bit keep, output int acc);
    int  n;
    bit  got;
    exp_t e;
    req_addr  = a;
    req_inv   = inv;
    req_valid = 1'b1;
    n   = 0;
    got = 1'b0;
    acc = -1;
    while (!got && n < 20) begin
      @(negedge clk);
      if (req_ready) got = 1'b1;
      else n++;
    end
    if (!got) begin
      check("accept_timeout", 0, 1);
      req_valid = 1'b0;
    end else begin
      model_req(a, inv, e);
      e.acc = cyc;
      acc   = cyc;
      q.push_back(e);
      @(posedge clk);
      #1;
      if (!keep) req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1);
    check("resp_after_reset", resp_valid, 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [I_SIZE-1:0] mk(input int tag, input int set);
    logic [I_SIZE-1:0] a;
    a = I_SIZE'((tag << (IDX_W + D_SIZE)) | (set << D_SIZE));
    return a;
  endfunction

  initial begin
    int acc;
    int accs[4];
    int n0;
    n_chk = 0; n_fail = 0; n_resp = 0; cyc = 0;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_inv = 1'b0;
    do_reset();

    // first access misses into way 0, repeat hits after two cycles
    send(mk(1, 0), 1'b0, 1'b0, acc);
    drain();
    check("r33_miss_hit", last_hit, 0);
    check("r33_miss_way", last_way, 0);
    check("r33_miss_evict", last_evict, 0);
    send(mk(1, 0), 1'b0, 1'b0, acc);
    drain();
    check("r33_hit", last_hit, 1);
    check("r33_hit_way", last_way, 0);
    check("r33_lat", last_lat, 2);

    // fill set 0, touch tag 1, then force a replacement
    do_reset();
    for (int t = 1; t <= 8; t++) send(mk(t, 0), 1'b0, 1'b0, acc);
    send(mk(1, 0), 1'b0, 1'b0, acc);
    send(mk(9, 0), 1'b0, 1'b0, acc);
    drain();
    check("r34_hit", last_hit, 0);
    check("r34_evict", last_evict, 1);
`ifdef TAG_WAY_MGR_LRU_EN
    check("r34_way", last_way, 1);
    check("r34_etag", last_etag, 2);
`else
    check("r34_way", last_way, 0);
    check("r34_etag", last_etag, 1);
`endif

    // invalidate hit, re-allocate, invalidate miss
    do_reset();
    send(mk(1, 0), 1'b0, 1'b0, acc);
    send(mk(1, 0), 1'b1, 1'b0, acc);
    drain();
    check("r35_inv_hit", last_hit, 1);
    check("r35_inv_way", last_way, 0);
    send(mk(1, 0), 1'b0, 1'b0, acc);
    drain();
    check("r35_realloc_hit", last_hit, 0);
    check("r35_realloc_way", last_way, 0);
    check("r35_realloc_evict", last_evict, 0);
    send(mk(2, 0), 1'b1, 1'b0, acc);
    drain();
    check("r35_inv_miss", last_hit, 0);
    check("r35_inv_miss_way", last_way, 0);

    // reset while a request sits in LOOKUP drops it silently
    do_reset();
    send(mk(1, 0), 1'b0, 1'b0, acc);
    n0 = n_resp;
    do_reset();
    check("r36_no_resp", n_resp - n0, 0);
    send(mk(1, 0), 1'b0, 1'b0, acc);
    drain();
    check("r36_miss", last_hit, 0);

    // valid held high across four different addresses
    do_reset();
    n0 = n_resp;
    send(mk(1, 0), 1'b0, 1'b1, accs[0]);
    send(mk(2, 0), 1'b0, 1'b1, accs[1]);
    send(mk(1, 1), 1'b0, 1'b1, accs[2]);
    send(mk(3, 0), 1'b0, 1'b1, accs[3]);
    req_valid = 1'b0;
    drain();
    for (int i = 1; i < 4; i++) check("r37_spacing", accs[i] - accs[i-1], 3);
    check("r37_count", n_resp - n0, 4);

    // randomised traffic over two sets with more tags than ways
    do_reset();
    for (int k = 0; k < 120; k++) begin
      logic [I_SIZE-1:0] a;
      a = mk($urandom_range(0, 11), $urandom_range(0, 1));
      a[D_SIZE-1:0] = D_SIZE'($urandom);
      send(a, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), acc);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/tag_way_manager.md
TAG_WAY_MANAGER -- requirements
Module: tag_way_manager

Interface
REQ-001 Parameter i_size, default 20, address width in bits.
REQ-002 Parameter c_size, default 12, log2 of cache capacity in bytes.
REQ-003 Parameter a_size, default 8, associativity in ways, a power of two and at least 2.
REQ-004 Parameter d_size, default 6, log2 of block size in bytes.
REQ-005 Derived widths SHALL be: idx_w = c_size-d_size-$clog2(a_size); tag_w = i_size-idx_w-d_size; way_w = $clog2(a_size).
REQ-006 The address SHALL split into tag [i_size-1 : idx_w+d_size], index [idx_w+d_size-1 : d_size] and offset [d_size-1 : 0].
REQ-007 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 req_valid  input  1  request present.
REQ-010 req_ready  output  1  request accepted when high together with req_valid.
REQ-011 req_addr  input  i_size  request address.
REQ-012 req_inv  input  1  0 = access (lookup/allocate), 1 = invalidate.
REQ-013 resp_valid  output  1  one-cycle response pulse.
REQ-014 resp_hit  output  1  tag matched a valid way.
REQ-015 resp_way  output  way_w  hit way, or allocated way on an access miss.
REQ-016 resp_evict  output  1  an access miss replaced a valid line.
REQ-017 resp_evict_tag  output  tag_w  tag of the replaced line.

Function
REQ-018 Storage SHALL be 2^idx_w sets x a_size ways, each way holding a tag and a valid bit, plus per-set replacement state.
REQ-019 The FSM SHALL have three states:
- IDLE: req_ready=1; a handshake registers the address and opcode and moves to LOOKUP.
- LOOKUP: compares the tag against all ways of the indexed set; always moves to UPDATE.
- UPDATE: commits the state change, pulses resp_valid, and returns to IDLE.
REQ-020 req_ready SHALL be 0 in LOOKUP and UPDATE; a request accepted at edge N SHALL produce resp_valid during cycle N+2. Throughput is one request per 3 cycles.
REQ-021 If multiple valid ways match, the lowest-index way SHALL be reported.
REQ-022 Access hit: resp_hit=1, resp_way=matching way, resp_evict=0; the way SHALL become most-recently-used (MRU).
REQ-023 Access miss: resp_hit=0 and a way SHALL be allocated:
- the lowest-index invalid way if any exists (resp_evict=0);
- otherwise the replacement victim (resp_evict=1, resp_evict_tag=old tag).
- The allocated way SHALL take the new tag, be marked valid, and become MRU.
REQ-024 Invalidate hit: resp_hit=1, resp_way=matching way, valid bit cleared, replacement state unchanged, resp_evict=0.
REQ-025 Invalidate miss: resp_hit=0, resp_way=0, no state change.
REQ-026 Outside resp_valid, resp_hit, resp_way, resp_evict and resp_evict_tag SHALL be 0.
REQ-027 Requests to different sets SHALL never affect each other's tags, valid bits or replacement state.

Reset
REQ-028 Reset SHALL force IDLE, clear all valid bits, drive resp_* to 0, and drop any in-flight request with no response.
REQ-029 Reset SHALL initialise replacement state: LRU ages to way i = i; round-robin pointer to 0.
REQ-030 req_ready SHALL be 0 while reset is high and 1 in the first cycle after it deasserts.

Configuration
REQ-031 With macro TAG_WAY_MGR_LRU_EN defined, replacement SHALL be true LRU:
- each way holds a way_w-bit age (0 = MRU);
- on a hit or allocate of way w, every way with age < age(w) increments and w is set to 0;
- the victim is the way with age a_size-1.
REQ-032 Without TAG_WAY_MGR_LRU_EN, replacement SHALL be a per-set round-robin pointer:
- the victim is the pointer way;
- the pointer increments modulo a_size only on an eviction;
- hits do not change the pointer.

Verification (default parameters; set 0 addresses = tag<<9)
REQ-033 After reset, access 0x00200 -> miss, way 0, evict 0; repeat -> hit, way 0, response 2 cycles after accept.
REQ-034 Fill set 0 with tags 1..8, access tag 1, then access tag 9 -> LRU build: way 1, evict 1, evict_tag 2; non-LRU build: way 0, evict_tag 1.
REQ-035 Allocate 0x00200, invalidate 0x00200 -> hit, way 0; access 0x00200 -> miss, way 0, evict 0; invalidate 0x00400 -> resp_hit 0.
REQ-036 Assert reset during LOOKUP -> no resp_valid, req_ready=1 the cycle after release, access 0x00200 -> miss.
REQ-037 Hold req_valid high continuously for 4 different addresses -> exactly 4 accepts spaced 3 cycles apart, 4 responses in order, none lost or duplicated.
